score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//   Game score and state tracker for Flappy; sits directly upstream of the binary-to-decimal digit splitter.
//   Counts pipe passes and bonus pickups during play, and saturates at the 5-digit display limit.
//   Latches the session high score at game over and enforces a restart lockout.
//   counter_out drives the digit splitter; high_score may drive a second splitter instance.
// PARAMETERS
//   WIDTH         32          width of counter_out and high_score
//   MAX_SCORE     99999       saturation ceiling (5 decimal digits)
//   BONUS_POINTS  5           points added per bonus pulse
//   HOLD_CYCLES   25000000    game-over lockout length in clk cycles (0.5 s at 50 MHz); must be >= 1
// PORTS
//   clk          in   1      system clock; all logic on posedge
//   reset        in   1      synchronous, active-high reset
//   start_game   in   1      level; request new game (sampled in IDLE / post-lockout GAME_OVER)
//   pipe_passed  in   1      level from collision/pipe logic; each rising edge scores +1
//   bonus        in   1      single-cycle pulse; scores +BONUS_POINTS
//   bird_hit     in   1      level; ends game while PLAYING
//   counter_out  out  WIDTH  current score (registered)
//   high_score   out  WIDTH  best score since reset (registered)
//   new_high     out  1      1 while in GAME_OVER if the last game set a new high score
//   game_state   out  2      0=IDLE, 1=PLAYING, 2=GAME_OVER (3 unused, never driven)
// BEHAVIOUR
//   Reset (sync, wins over everything):
//     game_state=IDLE; counter_out=0; high_score=0; new_high=0; edge reg=0; lockout timer=0.
//     Reset mid-game also clears high_score.
//   Edge detect:
//     pipe_prev <= pipe_passed every cycle in all states; rise = pipe_passed & ~pipe_prev.
//   IDLE:
//     counter_out holds the last game's score.
//     start_game=1 -> next cycle: PLAYING, counter_out=0, new_high=0.
//   PLAYING:
//     bird_hit=1 has priority; rise/bonus in the same cycle are discarded.
//     bird_hit=1 -> next cycle: GAME_OVER, timer=0.
//       If counter_out > high_score: high_score=counter_out and new_high=1, in the same cycle as the state change.
//       Equal score does not set new_high.
//     Else increment inc = rise + (bonus ? BONUS_POINTS : 0); rise and bonus together -> +1+BONUS_POINTS.
//     Score latency: 1 cycle after rise/bonus.
//     Saturation: counter_out = min(counter_out + inc, MAX_SCORE). Compute the sum at WIDTH+1 bits; no wrap.
//     start_game is ignored while PLAYING.
//   GAME_OVER:
//     counter_out and high_score frozen; timer increments each cycle, saturating at HOLD_CYCLES.
//     start_game is ignored while timer < HOLD_CYCLES.
//     Once timer == HOLD_CYCLES:
//       start_game=1 -> next cycle: PLAYING, counter_out=0, new_high=0.
//       start_game=0 -> remain in GAME_OVER; no automatic return to IDLE.
//     pipe_passed, bonus and bird_hit are ignored.
//   Outputs are all registered; no combinational input-to-output path.
// TESTING (bench overrides HOLD_CYCLES=4, BONUS_POINTS=5)
//   1. reset=1 for 2 cycles with all inputs=1 -> game_state=0, counter_out=0, high_score=0, new_high=0.
//   2. start_game pulse, then pipe_passed high for 10 cycles and low, repeated 3 times
//        -> counter_out=3; each increment appears 1 cycle after the rise.
//   3. While PLAYING with score 7, drive rise and bonus in the same cycle -> 13.
//      Then drive bird_hit together with a rise -> GAME_OVER, counter_out=13, high_score=13, new_high=1.
//   4. start_game held from GAME_OVER entry -> stays GAME_OVER for 4 cycles, then PLAYING; counter_out=0, new_high=0.
//      Score 13 again, then hit -> high_score=13, new_high=0.
//   5. Force score to 99997 (preload via 19999 bonus pulses + 2 rises), then pipe rises and bonus
//        -> counter_out stays 99999; no wrap.
//   6. Assert reset mid-PLAYING with score 40 and high_score 13 -> next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/score_keeper.sv
// Score and game-state tracker for Flappy.
// It counts pipe passes and bonus pickups during play and saturates at the display limit.
// At game over it latches the session high score, then holds a restart lockout.
// Every output comes straight from a register.
module score_keeper #(
    parameter int WIDTH        = 32,
    parameter int MAX_SCORE    = 99999,
    parameter int BONUS_POINTS = 5,
    parameter int HOLD_CYCLES  = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_game,
    input  logic             pipe_passed,
    input  logic             bonus,
    input  logic             bird_hit,
    output logic [WIDTH-1:0] counter_out,
    output logic [WIDTH-1:0] high_score,
    output logic             new_high,
    output logic [1:0]       game_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        GAME_OVER = 2'd2
    } gameState_t;

    localparam int                    TimerWidth   = $clog2(HOLD_CYCLES + 1);
    localparam logic [TimerWidth-1:0] HoldLimit    = TimerWidth'(HOLD_CYCLES);
    localparam logic [WIDTH:0]        MaxScoreWide = (WIDTH + 1)'(MAX_SCORE);
    localparam logic [WIDTH-1:0]      MaxScore     = WIDTH'(MAX_SCORE);
    localparam logic [WIDTH:0]        BonusWide    = (WIDTH + 1)'(BONUS_POINTS);

    gameState_t            state_q, state_d;
    logic [WIDTH-1:0]      score_q, score_d;
    logic [WIDTH-1:0]      highScore_q, highScore_d;
    logic                  newHigh_q, newHigh_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic                  pipePrev_q;

    logic                  pipeRise;
    logic                  lockoutDone;
    logic [WIDTH:0]        scoreSum;
    logic [WIDTH-1:0]      scoreSat;

    // The pipe_passed level can stay high for many cycles. Only its rising edge scores.
    assign pipeRise    = pipe_passed & ~pipePrev_q;
    assign lockoutDone = (timer_q == HoldLimit);

    // The sum is one bit wider than the score, so an increment near the ceiling cannot wrap.
    assign scoreSum = {1'b0, score_q} + {{WIDTH{1'b0}}, pipeRise} + (bonus ? BonusWide : '0);
    assign scoreSat = (scoreSum > MaxScoreWide) ? MaxScore : scoreSum[WIDTH-1:0];

    // State register and datapath registers. Reset is synchronous and clears everything, high score included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            highScore_q <= '0;
            newHigh_q   <= 1'b0;
            timer_q     <= '0;
            pipePrev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            highScore_q <= highScore_d;
            newHigh_q   <= newHigh_d;
            timer_q     <= timer_d;
            pipePrev_q  <= pipe_passed;
        end
    end

    // Next-state logic. A restart from GAME_OVER is allowed only after the lockout timer reaches its limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_game) state_d = PLAYING;
            PLAYING:   if (bird_hit) state_d = GAME_OVER;
            GAME_OVER: if (lockoutDone && start_game) state_d = PLAYING;
            default:   state_d = IDLE;
        endcase
    end

    // Next values for score, high score, new-high flag and lockout timer, which all depend on the current state.
    always_comb begin
        score_d     = score_q;
        highScore_d = highScore_q;
        newHigh_d   = newHigh_q;
        timer_d     = timer_q;
        case (state_q)
            IDLE: begin
                if (start_game) begin
                    score_d   = '0;
                    newHigh_d = 1'b0;
                end
            end
            PLAYING: begin
                if (bird_hit) begin
                    timer_d = '0;
                    if (score_q > highScore_q) begin
                        highScore_d = score_q;
                        newHigh_d   = 1'b1;
                    end
                end else begin
                    score_d = scoreSat;
                end
            end
            GAME_OVER: begin
                if (lockoutDone) begin
                    if (start_game) begin
                        score_d   = '0;
                        newHigh_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + TimerWidth'(1);
                end
            end
            default: begin
                score_d = score_q;
            end
        endcase
    end

    assign counter_out = score_q;
    assign high_score  = highScore_q;
    assign new_high    = newHigh_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper.
// Directed scenarios cover reset, edge scoring, bonus, high score, lockout and saturation.
// A randomized phase follows. All outputs are checked every cycle against a behavioural model of the game rules.
module tb_score_keeper;

    localparam int Width       = 32;
    localparam int MaxScore    = 99999;
    localparam int BonusPoints = 5;
    localparam int HoldCycles  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             startGame;
    logic             pipePassed;
    logic             bonusIn;
    logic             birdHit;
    logic [Width-1:0] counterOut;
    logic [Width-1:0] highScore;
    logic             newHigh;
    logic [1:0]       gameState;

    int checksRun    = 0;
    int checksPassed = 0;

    // Model of the game rules, kept in plain integers.
    int     mState   = 0;
    longint mScore   = 0;
    longint mHigh    = 0;
    int     mNewHigh = 0;
    int     mTimer   = 0;
    int     mPrevPipe = 0;

    score_keeper #(
        .WIDTH       (Width),
        .MAX_SCORE   (MaxScore),
        .BONUS_POINTS(BonusPoints),
        .HOLD_CYCLES (HoldCycles)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_game (startGame),
        .pipe_passed(pipePassed),
        .bonus      (bonusIn),
        .bird_hit   (birdHit),
        .counter_out(counterOut),
        .high_score (highScore),
        .new_high   (newHigh),
        .game_state (gameState)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // One comparison. The result is counted, and a mismatch is reported with both values.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checksRun++;
        if (observed == expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Advances the model by one clock edge, using the inputs as they stand before that edge.
    task automatic modelStep();
        longint sum;
        int rise;
        rise = (pipePassed && mPrevPipe == 0) ? 1 : 0;
        if (reset) begin
            mState = 0; mScore = 0; mHigh = 0; mNewHigh = 0; mTimer = 0; mPrevPipe = 0;
        end else begin
            if (mState == 0) begin
                if (startGame) begin mState = 1; mScore = 0; mNewHigh = 0; end
            end else if (mState == 1) begin
                if (birdHit) begin
                    mState = 2;
                    mTimer = 0;
                    if (mScore > mHigh) begin mHigh = mScore; mNewHigh = 1; end
                end else begin
                    sum = mScore + rise + (bonusIn ? BonusPoints : 0);
                    mScore = (sum > MaxScore) ? MaxScore : sum;
                end
            end else begin
                if (mTimer == HoldCycles) begin
                    if (startGame) begin mState = 1; mScore = 0; mNewHigh = 0; end
                end else begin
                    mTimer++;
                end
            end
            mPrevPipe = pipePassed ? 1 : 0;
        end
    endtask

    // Runs one clock cycle, then compares every output against the model shortly after the edge.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("game_state", gameState, mState);
        checkOutput("counter_out", counterOut, mScore);
        checkOutput("high_score", highScore, mHigh);
        checkOutput("new_high", newHigh, mNewHigh);
    endtask

    // Applies one set of input levels and holds them for the given number of cycles.
    task automatic applyStimulus(input logic st, input logic pp, input logic bn, input logic bh,
                                 input logic rs, input int cycles);
        startGame = st; pipePassed = pp; bonusIn = bn; birdHit = bh; reset = rs;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Directed scenarios first, then a randomized phase, then the summary line.
    initial begin
        startGame = 1'b0; pipePassed = 1'b0; bonusIn = 1'b0; birdHit = 1'b0; reset = 1'b0;
        #2;

        $display("[TB] reset with all inputs high");
        applyStimulus(1, 1, 1, 1, 1, 2);
        checkOutput("reset state", gameState, 0);
        checkOutput("reset score", counterOut, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] start and three pipe passes");
        applyStimulus(1, 0, 0, 0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 1, 0, 0, 0, 10);
            applyStimulus(0, 0, 0, 0, 0, 10);
        end
        checkOutput("three passes", counterOut, 3);

        $display("[TB] rise with bonus, then hit with rise");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(0, 1, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        checkOutput("score seven", counterOut, 7);
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("rise plus bonus", counterOut, 13);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 0, 1);
        checkOutput("hit state", gameState, 2);
        checkOutput("hit score", counterOut, 13);
        checkOutput("hit high", highScore, 13);
        checkOutput("hit new_high", newHigh, 1);

        $display("[TB] lockout with start held");
        applyStimulus(1, 0, 0, 0, 0, 4);
        checkOutput("locked out", gameState, 2);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("restart state", gameState, 1);
        checkOutput("restart score", counterOut, 0);
        checkOutput("restart new_high", newHigh, 0);
        applyStimulus(0, 0, 1, 0, 0, 2);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 1, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("equal high", highScore, 13);
        checkOutput("equal new_high", newHigh, 0);

        $display("[TB] reset in the middle of a game");
        applyStimulus(1, 0, 0, 0, 0, 5);
        applyStimulus(0, 0, 1, 0, 0, 8);
        checkOutput("score forty", counterOut, 40);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("midreset state", gameState, 0);
        checkOutput("midreset high", highScore, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] saturation at the display limit");
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 19999);
        for (int r = 0; r < 2; r++) begin
            applyStimulus(0, 1, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0, 1);
        end
        checkOutput("preload", counterOut, 99997);
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("saturate", counterOut, 99999);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 0, 1, 0, 0, 1);
            applyStimulus(0, 1, 0, 0, 0, 1);
        end
        checkOutput("no wrap", counterOut, 99999);

        $display("[TB] randomized play");
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            startGame  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) pipePassed = ~pipePassed;
            bonusIn    = ($urandom_range(0, 3) == 0);
            birdHit    = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
